pc_fetch_sequencer: RTL and testbench

- Program-counter register and instruction-fetch sequencer: the producer side of the branch-target adder path.
- Outputs PcNext (InstrPc + 4) for the adder to combine with the shifted offset.
- Accepts the adder's result back as BranchTarget, plus a jump target.
- Drives a req/ready handshake to instruction memory and holds one fetched instruction for decode.

---
 rtl/pc_fetch_sequencer_if.sv | 33 +++
 rtl/pc_fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if
// Groups every non-clock, non-reset signal of the fetch sequencer:
//   decode side  : Stall (in), InstrValid/Instr/InstrPc (out)
//   PC adder     : PcNext (out), BranchTarget (in)
//   redirects    : Branch/Jump strobes and JumpTarget (in), sticky AlignErr (out)
//   imem bus     : ImemReq/ImemAddr (out), ImemReady/ImemData (in)
// master = the sequencer's view, slave = the surrounding environment.
interface pc_fetch_sequencer_if;
  logic        Stall;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
  logic [31:0] PcNext;
  logic        AlignErr;

  modport master (
    input  Stall, Branch, BranchTarget, Jump, JumpTarget, ImemReady, ImemData,
    output ImemReq, ImemAddr, InstrValid, Instr, InstrPc, PcNext, AlignErr
  );

  modport slave (
    output Stall, Branch, BranchTarget, Jump, JumpTarget, ImemReady, ImemData,
    input  ImemReq, ImemAddr, InstrValid, Instr, InstrPc, PcNext, AlignErr
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Program counter plus instruction-fetch sequencer. Issues fetches to
// instruction memory over a req/ready handshake, buffers one fetched
// instruction for decode, exports PcNext (InstrPc + PC_STEP) to the branch
// target adder and accepts branch/jump redirects.
// Ports:
//   Clk   - rising-edge clock
//   Reset - synchronous, active-high reset
//   bus   - pc_fetch_sequencer_if.master (decode, redirect and imem signals)
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  pc_fetch_sequencer_if.master bus
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_imemAddr;
  logic        r_imemReq;
  logic        r_instrValid;
  logic [31:0] r_instr;
  logic [31:0] r_instrPc;
  logic        r_alignErr;

  logic        w_full;
  logic        w_req;
  logic        w_fire;
  logic        w_outstanding;
  logic        w_consume;
  logic        w_redirect;
  logic [31:0] w_rawTarget;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic [31:0] w_pcInc;

  // The request is masked in the same cycle the buffer is full, so a
  // completing fetch can never overwrite an instruction decode has not taken.
  assign w_full        = r_instrValid & bus.Stall;
  assign w_req         = r_imemReq & ~w_full;
  assign w_fire        = w_req & bus.ImemReady;
  assign w_outstanding = w_req & ~bus.ImemReady;
  assign w_consume     = r_instrValid & ~bus.Stall;

  // Jump outranks Branch; the target is word-aligned by dropping bits [1:0].
  assign w_redirect   = bus.Jump | bus.Branch;
  assign w_rawTarget  = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
  assign w_target     = {w_rawTarget[31:2], 2'b00};
  assign w_misaligned = |w_rawTarget[1:0];
  assign w_pcInc      = r_pc + STEP;

  assign bus.ImemReq    = w_req;
  assign bus.ImemAddr   = r_imemAddr;
  assign bus.InstrValid = r_instrValid;
  assign bus.Instr      = r_instr;
  assign bus.InstrPc    = r_instrPc;
  assign bus.PcNext     = r_instrPc + STEP;
  assign bus.AlignErr   = r_alignErr;

  // During DISCARD the redirect target already sits in r_pc while r_imemAddr
  // keeps the old address, so the outstanding request stays stable until the
  // memory answers; a later redirect simply overwrites r_pc again.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_VECTOR;
      r_imemAddr   <= RESET_VECTOR;
      r_imemReq    <= 1'b0;
      r_instrValid <= 1'b0;
      r_instr      <= 32'h0;
      r_instrPc    <= 32'h0;
      r_alignErr   <= 1'b0;
    end else if (w_redirect) begin
      r_instrValid <= 1'b0;
      if (w_misaligned) begin
        r_alignErr <= 1'b1;
      end
      r_pc      <= w_target;
      r_imemReq <= 1'b1;
      if (w_outstanding) begin
        r_state <= DISCARD;
      end else begin
        r_state    <= FETCH;
        r_imemAddr <= w_target;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imemReq  <= 1'b1;
          r_imemAddr <= r_pc;
        end
        FETCH: begin
          if (w_fire) begin
            r_instr      <= bus.ImemData;
            r_instrPc    <= r_pc;
            r_instrValid <= 1'b1;
            r_pc         <= w_pcInc;
            r_imemAddr   <= w_pcInc;
          end else if (w_consume) begin
            r_instrValid <= 1'b0;
          end
        end
        DISCARD: begin
          if (bus.ImemReady) begin
            r_state    <= FETCH;
            r_imemAddr <= r_pc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
// Directed self-checking bench for pc_fetch_sequencer. Inputs change and
// outputs are sampled one or two time units after the rising edge.
module tb_pc_fetch_sequencer;

  logic Clk = 1'b0;
  logic Reset;
  int   nCompared   = 0;
  int   nMismatched = 0;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .PC_STEP     (4)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic waitCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Stall = 1'b0; bus.Branch = 1'b0; bus.Jump = 1'b0;
    bus.BranchTarget = 32'h0; bus.JumpTarget = 32'h0;
    bus.ImemReady = 1'b1; bus.ImemData = 32'h0;
    waitCycle();
    waitCycle();
    nCompared++; if (bus.ImemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req got %h expected %h", bus.ImemReq, 1'b0); end
    nCompared++; if (bus.ImemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_addr got %h expected %h", bus.ImemAddr, 32'h0); end
    nCompared++; if (bus.InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %h expected %h", bus.InstrValid, 1'b0); end
    nCompared++; if (bus.Instr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_instr got %h expected %h", bus.Instr, 32'h0); end
    nCompared++; if (bus.InstrPc !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_instrpc got %h expected %h", bus.InstrPc, 32'h0); end
    nCompared++; if (bus.AlignErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_alignerr got %h expected %h", bus.AlignErr, 1'b0); end
  endtask

  task automatic test_sequential();
    Reset = 1'b0;
    #1;
    nCompared++; if (bus.ImemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL seq_bubble got %h expected %h", bus.ImemReq, 1'b0); end
    waitCycle();
    nCompared++; if (bus.ImemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_req0 got %h expected %h", bus.ImemReq, 1'b1); end
    nCompared++; if (bus.ImemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL seq_addr0 got %h expected %h", bus.ImemAddr, 32'h0); end
    bus.ImemData = 32'h1000_0000;
    waitCycle();
    nCompared++; if (bus.ImemAddr !== 32'h4) begin nMismatched++; $display("[TB] FAIL seq_addr4 got %h expected %h", bus.ImemAddr, 32'h4); end
    nCompared++; if (bus.InstrValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_valid got %h expected %h", bus.InstrValid, 1'b1); end
    nCompared++; if (bus.Instr !== 32'h1000_0000) begin nMismatched++; $display("[TB] FAIL seq_instr0 got %h expected %h", bus.Instr, 32'h1000_0000); end
    nCompared++; if (bus.InstrPc !== 32'h0) begin nMismatched++; $display("[TB] FAIL seq_instrpc0 got %h expected %h", bus.InstrPc, 32'h0); end
    nCompared++; if (bus.PcNext !== 32'h4) begin nMismatched++; $display("[TB] FAIL seq_pcnext4 got %h expected %h", bus.PcNext, 32'h4); end
    bus.ImemData = 32'h1000_0004;
    waitCycle();
    nCompared++; if (bus.ImemAddr !== 32'h8) begin nMismatched++; $display("[TB] FAIL seq_addr8 got %h expected %h", bus.ImemAddr, 32'h8); end
    nCompared++; if (bus.Instr !== 32'h1000_0004) begin nMismatched++; $display("[TB] FAIL seq_instr4 got %h expected %h", bus.Instr, 32'h1000_0004); end
    nCompared++; if (bus.InstrPc !== 32'h4) begin nMismatched++; $display("[TB] FAIL seq_instrpc4 got %h expected %h", bus.InstrPc, 32'h4); end
  endtask

  task automatic test_stall();
    bus.ImemData = 32'h2001_0005;
    waitCycle();
    bus.Stall = 1'b1;
    #1;
    nCompared++; if (bus.ImemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_req_now got %h expected %h", bus.ImemReq, 1'b0); end
    bus.ImemData = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      nCompared++; if (bus.Instr !== 32'h2001_0005) begin nMismatched++; $display("[TB] FAIL stall_instr c%0d got %h expected %h", i, bus.Instr, 32'h2001_0005); end
      nCompared++; if (bus.InstrPc !== 32'h8) begin nMismatched++; $display("[TB] FAIL stall_instrpc c%0d got %h expected %h", i, bus.InstrPc, 32'h8); end
      nCompared++; if (bus.InstrValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_valid c%0d got %h expected %h", i, bus.InstrValid, 1'b1); end
      nCompared++; if (bus.ImemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_req c%0d got %h expected %h", i, bus.ImemReq, 1'b0); end
      nCompared++; if (bus.ImemAddr !== 32'hC) begin nMismatched++; $display("[TB] FAIL stall_addr c%0d got %h expected %h", i, bus.ImemAddr, 32'hC); end
    end
    bus.Stall = 1'b0;
    bus.ImemData = 32'h1000_000C;
    #1;
    nCompared++; if (bus.ImemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_resume_req got %h expected %h", bus.ImemReq, 1'b1); end
    nCompared++; if (bus.ImemAddr !== 32'hC) begin nMismatched++; $display("[TB] FAIL stall_resume_addr got %h expected %h", bus.ImemAddr, 32'hC); end
    waitCycle();
    nCompared++; if (bus.InstrPc !== 32'hC) begin nMismatched++; $display("[TB] FAIL stall_next_instrpc got %h expected %h", bus.InstrPc, 32'hC); end
    nCompared++; if (bus.Instr !== 32'h1000_000C) begin nMismatched++; $display("[TB] FAIL stall_next_instr got %h expected %h", bus.Instr, 32'h1000_000C); end
  endtask

  task automatic test_branch();
    bus.Branch = 1'b1;
    bus.BranchTarget = 32'h0000_0110;
    bus.ImemData = 32'hDEAD_BEEF;
    waitCycle();
    bus.Branch = 1'b0;
    nCompared++; if (bus.InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL br_flush got %h expected %h", bus.InstrValid, 1'b0); end
    nCompared++; if (bus.ImemAddr !== 32'h110) begin nMismatched++; $display("[TB] FAIL br_addr got %h expected %h", bus.ImemAddr, 32'h110); end
    nCompared++; if (bus.ImemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL br_req got %h expected %h", bus.ImemReq, 1'b1); end
    bus.ImemData = 32'h3000_0110;
    waitCycle();
    nCompared++; if (bus.InstrPc !== 32'h110) begin nMismatched++; $display("[TB] FAIL br_instrpc got %h expected %h", bus.InstrPc, 32'h110); end
    nCompared++; if (bus.PcNext !== 32'h114) begin nMismatched++; $display("[TB] FAIL br_pcnext got %h expected %h", bus.PcNext, 32'h114); end
    nCompared++; if (bus.Instr !== 32'h3000_0110) begin nMismatched++; $display("[TB] FAIL br_instr got %h expected %h", bus.Instr, 32'h3000_0110); end
    nCompared++; if (bus.ImemAddr !== 32'h114) begin nMismatched++; $display("[TB] FAIL br_addr_next got %h expected %h", bus.ImemAddr, 32'h114); end
  endtask

  task automatic test_discard();
    Reset = 1'b1;
    bus.ImemReady = 1'b1;
    waitCycle();
    Reset = 1'b0;
    waitCycle();
    waitCycle();
    waitCycle();
    nCompared++; if (bus.ImemAddr !== 32'h8) begin nMismatched++; $display("[TB] FAIL dis_setup_addr got %h expected %h", bus.ImemAddr, 32'h8); end
    bus.ImemReady = 1'b0;
    waitCycle();
    nCompared++; if (bus.InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL dis_consumed got %h expected %h", bus.InstrValid, 1'b0); end
    bus.Jump = 1'b1;
    bus.JumpTarget = 32'h40;
    waitCycle();
    bus.Jump = 1'b0;
    nCompared++; if (bus.ImemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL dis_req_held got %h expected %h", bus.ImemReq, 1'b1); end
    nCompared++; if (bus.ImemAddr !== 32'h8) begin nMismatched++; $display("[TB] FAIL dis_addr_held got %h expected %h", bus.ImemAddr, 32'h8); end
    bus.ImemReady = 1'b1;
    bus.ImemData = 32'hBAD0_0008;
    waitCycle();
    nCompared++; if (bus.InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL dis_dropped got %h expected %h", bus.InstrValid, 1'b0); end
    nCompared++; if (bus.ImemAddr !== 32'h40) begin nMismatched++; $display("[TB] FAIL dis_target_addr got %h expected %h", bus.ImemAddr, 32'h40); end
    nCompared++; if (bus.ImemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL dis_target_req got %h expected %h", bus.ImemReq, 1'b1); end
    bus.ImemData = 32'h4000_0040;
    waitCycle();
    nCompared++; if (bus.InstrPc !== 32'h40) begin nMismatched++; $display("[TB] FAIL dis_instrpc got %h expected %h", bus.InstrPc, 32'h40); end
    nCompared++; if (bus.Instr !== 32'h4000_0040) begin nMismatched++; $display("[TB] FAIL dis_instr got %h expected %h", bus.Instr, 32'h4000_0040); end
  endtask

  task automatic test_priority_align();
    bus.Branch = 1'b1; bus.BranchTarget = 32'h100;
    bus.Jump = 1'b1;   bus.JumpTarget = 32'h200;
    waitCycle();
    bus.Jump = 1'b0;
    nCompared++; if (bus.ImemAddr !== 32'h200) begin nMismatched++; $display("[TB] FAIL prio_addr got %h expected %h", bus.ImemAddr, 32'h200); end
    nCompared++; if (bus.InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_flush got %h expected %h", bus.InstrValid, 1'b0); end
    nCompared++; if (bus.AlignErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_alignerr got %h expected %h", bus.AlignErr, 1'b0); end
    bus.Branch = 1'b1; bus.BranchTarget = 32'h103;
    waitCycle();
    bus.Branch = 1'b0;
    nCompared++; if (bus.ImemAddr !== 32'h100) begin nMismatched++; $display("[TB] FAIL align_addr got %h expected %h", bus.ImemAddr, 32'h100); end
    nCompared++; if (bus.AlignErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL align_err got %h expected %h", bus.AlignErr, 1'b1); end
    bus.ImemData = 32'h6000_0000;
    waitCycle();
    waitCycle();
    nCompared++; if (bus.AlignErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL align_sticky got %h expected %h", bus.AlignErr, 1'b1); end
    nCompared++; if (bus.InstrPc !== 32'h104) begin nMismatched++; $display("[TB] FAIL align_instrpc got %h expected %h", bus.InstrPc, 32'h104); end
    nCompared++; if (bus.ImemAddr !== 32'h108) begin nMismatched++; $display("[TB] FAIL align_next_addr got %h expected %h", bus.ImemAddr, 32'h108); end
  endtask

  task automatic test_wrap();
    bus.Jump = 1'b1;
    bus.JumpTarget = 32'hFFFF_FFFC;
    waitCycle();
    bus.Jump = 1'b0;
    bus.ImemData = 32'h5000_0000;
    nCompared++; if (bus.ImemAddr !== 32'hFFFF_FFFC) begin nMismatched++; $display("[TB] FAIL wrap_addr_top got %h expected %h", bus.ImemAddr, 32'hFFFF_FFFC); end
    waitCycle();
    nCompared++; if (bus.ImemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_addr_zero got %h expected %h", bus.ImemAddr, 32'h0); end
    nCompared++; if (bus.InstrPc !== 32'hFFFF_FFFC) begin nMismatched++; $display("[TB] FAIL wrap_instrpc got %h expected %h", bus.InstrPc, 32'hFFFF_FFFC); end
    nCompared++; if (bus.PcNext !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_pcnext got %h expected %h", bus.PcNext, 32'h0); end
  endtask

  task automatic test_reset_mid_fetch();
    bus.ImemReady = 1'b0;
    waitCycle();
    nCompared++; if (bus.ImemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_outstanding got %h expected %h", bus.ImemReq, 1'b1); end
    Reset = 1'b1;
    waitCycle();
    nCompared++; if (bus.ImemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_req got %h expected %h", bus.ImemReq, 1'b0); end
    nCompared++; if (bus.ImemAddr !== 32'h0) begin nMismatched++; $display("[TB] FAIL rmid_addr got %h expected %h", bus.ImemAddr, 32'h0); end
    nCompared++; if (bus.InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_valid got %h expected %h", bus.InstrValid, 1'b0); end
    nCompared++; if (bus.Instr !== 32'h0) begin nMismatched++; $display("[TB] FAIL rmid_instr got %h expected %h", bus.Instr, 32'h0); end
    nCompared++; if (bus.InstrPc !== 32'h0) begin nMismatched++; $display("[TB] FAIL rmid_instrpc got %h expected %h", bus.InstrPc, 32'h0); end
    nCompared++; if (bus.AlignErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_alignerr got %h expected %h", bus.AlignErr, 1'b0); end
    Reset = 1'b0;
    bus.ImemReady = 1'b1;
    bus.ImemData = 32'h0000_0BAD;
    #1;
    nCompared++; if (bus.ImemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_late_ready_req got %h expected %h", bus.ImemReq, 1'b0); end
    waitCycle();
    nCompared++; if (bus.InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_late_ignored got %h expected %h", bus.InstrValid, 1'b0); end
    nCompared++; if (bus.Instr !== 32'h0) begin nMismatched++; $display("[TB] FAIL rmid_late_instr got %h expected %h", bus.Instr, 32'h0); end
    nCompared++; if (bus.ImemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_refetch_req got %h expected %h", bus.ImemReq, 1'b1); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_discard();
    test_priority_align();
    test_wrap();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
